// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding (decoded from o_state by the
// register map) and the default timing constants.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SEQ       = 3'd1,
        ST_RUN       = 3'd2,
        ST_DSP_PULSE = 3'd3,
        ST_BLANK     = 3'd4,
        ST_LOCKOUT   = 3'd5
    } state_t;

    localparam int DEF_LOCK_FILT   = 4;
    localparam int DEF_STAGE_DLY   = 8;
    localparam int DEF_DSP_RST_CYC = 5;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_RETRY_CLR   = 1000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One counter width fits every timer, so a single timer module serves all of them.
    function automatic int cnt_width(input int lf, input int sd, input int dr, input int rc);
        return $clog2(max_int(max_int(lf, sd), max_int(dr, rc)) + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module reset_sequencer_seq_timer #(
    parameter int           W       = 10,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: qualifies DCM lock, releases core/unit/DSP/PWM resets in order and
// handles DSP faults with a retry budget that ends in lockout.
//  state        | meaning
//  WAIT_LOCK    | all resets held, filtering DCM lock
//  SEQ          | releasing core, unit, DSP, PWM one stage apart
//  RUN          | normal operation, watching faults and sw requests
//  DSP_PULSE    | PWM safed, DSP held in reset for the pulse width
//  BLANK        | DSP running, PWM still safed, events ignored
//  LOCKOUT      | retry budget exhausted, PWM and DSP held until cleared
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int LOCK_FILT   = DEF_LOCK_FILT,
    parameter int STAGE_DLY   = DEF_STAGE_DLY,
    parameter int DSP_RST_CYC = DEF_DSP_RST_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int RETRY_CLR   = DEF_RETRY_CLR,
    parameter int RW          = $clog2(MAX_RETRY + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_DcmLock,
    input  logic          i_wd_dsp_err,
    input  logic          i_xint_dsp_err,
    input  logic          i_sw_req,
    input  logic          i_clr_lockout,
    output logic          o_reset_n_core,
    output logic          o_reset_n_unit,
    output logic          o_reset_n_pwm,
    output logic          o_dsp_rst_n,
    output logic [2:0]    o_state,
    output logic [RW-1:0] o_retry_cnt,
    output logic          o_lockout
);
    localparam int            CW        = cnt_width(LOCK_FILT, STAGE_DLY, DSP_RST_CYC, RETRY_CLR);
    localparam logic [CW-1:0] LOCK_LD   = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] STAGE_LD  = CW'(STAGE_DLY - 1);
    localparam logic [CW-1:0] PULSE_LD  = CW'(DSP_RST_CYC - 1);
    localparam logic [CW-1:0] CLR_LD    = CW'(RETRY_CLR - 1);
    localparam logic [RW-1:0] RETRY_SAT = '1;

    state_t        state, state_nxt;
    logic [1:0]    stage, stage_nxt;
    logic          phase_load;
    logic [CW-1:0] phase_val;
    logic          lock_done, phase_done, clr_tmr_done, clr_done;
    logic          lock_lost, fault, retry_hit;
    logic          core_nxt, unit_nxt, pwm_nxt, dsp_nxt, lockout_nxt;
    logic [RW-1:0] retry_nxt;

    assign lock_lost = !i_DcmLock && (state != ST_WAIT_LOCK);
    assign fault     = i_wd_dsp_err | i_xint_dsp_err;
    assign retry_hit = (int'(o_retry_cnt) + 1) >= MAX_RETRY;
    assign clr_done  = clr_tmr_done && (state == ST_RUN);
    assign o_state   = state;

    // Lock filter stays armed at LOCK_FILT-1 until consecutive high samples count it down.
    reset_sequencer_seq_timer #(.W(CW), .RST_VAL(LOCK_LD)) u_lock_tmr (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  ((state != ST_WAIT_LOCK) || !i_DcmLock),
        .value (LOCK_LD),
        .done  (lock_done)
    );

    reset_sequencer_seq_timer #(.W(CW), .RST_VAL('0)) u_phase_tmr (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (phase_load),
        .value (phase_val),
        .done  (phase_done)
    );

    reset_sequencer_seq_timer #(.W(CW), .RST_VAL(CLR_LD)) u_clr_tmr (
        .clk   (i_clk),
        .rst   (i_rst),
        .load  (state != ST_RUN),
        .value (CLR_LD),
        .done  (clr_tmr_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_WAIT_LOCK;
            stage          <= '0;
            o_reset_n_core <= 1'b0;
            o_reset_n_unit <= 1'b0;
            o_reset_n_pwm  <= 1'b0;
            o_dsp_rst_n    <= 1'b0;
            o_retry_cnt    <= '0;
            o_lockout      <= 1'b0;
        end else begin
            state          <= state_nxt;
            stage          <= stage_nxt;
            o_reset_n_core <= core_nxt;
            o_reset_n_unit <= unit_nxt;
            o_reset_n_pwm  <= pwm_nxt;
            o_dsp_rst_n    <= dsp_nxt;
            o_retry_cnt    <= retry_nxt;
            o_lockout      <= lockout_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        stage_nxt  = stage;
        phase_load = 1'b0;
        phase_val  = STAGE_LD;
        if (lock_lost) begin
            state_nxt = ST_WAIT_LOCK;
        end else begin
            case (state)
                ST_WAIT_LOCK: begin
                    if (i_DcmLock && lock_done) begin
                        state_nxt  = o_lockout ? ST_LOCKOUT : ST_SEQ;
                        stage_nxt  = '0;
                        phase_load = 1'b1;
                    end
                end
                ST_SEQ: begin
                    if (phase_done) begin
                        phase_load = 1'b1;
                        if (stage == 2'd3) begin
                            state_nxt = ST_RUN;
                        end else begin
                            stage_nxt = stage + 2'd1;
                        end
                    end
                end
                ST_RUN: begin
                    if (fault) begin
                        state_nxt  = retry_hit ? ST_LOCKOUT : ST_DSP_PULSE;
                        phase_load = 1'b1;
                        phase_val  = PULSE_LD;
                    end else if (i_sw_req) begin
                        state_nxt  = ST_DSP_PULSE;
                        phase_load = 1'b1;
                        phase_val  = PULSE_LD;
                    end
                end
                ST_DSP_PULSE: begin
                    if (phase_done) begin
                        state_nxt  = ST_BLANK;
                        phase_load = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (phase_done) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_LOCKOUT: begin
                    if (i_clr_lockout) begin
                        state_nxt  = ST_DSP_PULSE;
                        phase_load = 1'b1;
                        phase_val  = PULSE_LD;
                    end
                end
                default: state_nxt = ST_WAIT_LOCK;
            endcase
        end
    end

    always_comb begin
        core_nxt    = o_reset_n_core;
        unit_nxt    = o_reset_n_unit;
        pwm_nxt     = o_reset_n_pwm;
        dsp_nxt     = o_dsp_rst_n;
        retry_nxt   = o_retry_cnt;
        lockout_nxt = o_lockout;
        if (lock_lost) begin
            core_nxt = 1'b0;
            unit_nxt = 1'b0;
            pwm_nxt  = 1'b0;
            dsp_nxt  = 1'b0;
        end else begin
            case (state)
                ST_SEQ: begin
                    if (phase_done) begin
                        case (stage)
                            2'd0:    core_nxt = 1'b1;
                            2'd1:    unit_nxt = 1'b1;
                            2'd2:    dsp_nxt  = 1'b1;
                            default: pwm_nxt  = 1'b1;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (fault) begin
                        pwm_nxt     = 1'b0;
                        dsp_nxt     = 1'b0;
                        retry_nxt   = (o_retry_cnt == RETRY_SAT) ? o_retry_cnt : o_retry_cnt + 1'b1;
                        lockout_nxt = retry_hit;
                    end else if (i_sw_req) begin
                        pwm_nxt = 1'b0;
                        dsp_nxt = 1'b0;
                    end else if (clr_done) begin
                        retry_nxt = '0;
                    end
                end
                ST_DSP_PULSE: begin
                    if (phase_done) begin
                        dsp_nxt = 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (phase_done) begin
                        pwm_nxt = 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    pwm_nxt = 1'b0;
                    dsp_nxt = 1'b0;
                    if (i_clr_lockout) begin
                        retry_nxt   = '0;
                        lockout_nxt = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
